shift_add_mult: RTL and testbench
=================================

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiply; sampled only when ready=1.
REQ-005 SHALL have port a, input, WIDTH bits: multiplicand; captured on the accepted start edge.
REQ-006 SHALL have port b, input, WIDTH bits: multiplier; captured on the accepted start edge.
REQ-007 SHALL have port ready, output, 1 bit: high only in IDLE; the block accepts start.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking p valid for a new result.
REQ-009 SHALL have port p, output, 2*WIDTH bits: product register.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-011 In IDLE with start=1 at a rising edge, SHALL capture a and b and clear the partial product and the iteration counter; next state is RUN.
REQ-012 In RUN, each edge SHALL perform one shift-add step: if the current multiplier LSB is 1, add the multiplicand to the upper WIDTH+1 bits of the partial product; then shift right by one bit. Carry-out SHALL be kept in the extra bit.
REQ-013 The iteration counter SHALL count 0..WIDTH-1. After the WIDTH-th RUN edge, the FSM SHALL load p with the full 2*WIDTH-bit result and move to DONE.
REQ-014 done SHALL be 1 for exactly the one cycle spent in DONE; the next edge SHALL return the FSM to IDLE unconditionally.
REQ-015 Latency: if start is accepted at edge t0, done SHALL be high between edges t0+WIDTH and t0+WIDTH+1. Throughput is one result per WIDTH+2 cycles.
REQ-016 start while ready=0 (RUN or DONE) SHALL be ignored, with no effect on operands or result. It is not queued.
REQ-017 a and b SHALL be don't-care outside the accepting edge; changing them mid-operation SHALL NOT affect the result.
REQ-018 p SHALL hold its last result until the next completion; it SHALL NOT show intermediate partial products.
REQ-019 Unsigned result SHALL equal a*b exactly, with no overflow possible (2*WIDTH bits).
REQ-020 Zero operands SHALL still take the full WIDTH iterations, with no early termination.

Reset
REQ-021 rst=1 at a rising edge SHALL force IDLE, and set p=0, done=0, ready=1, counter=0 and internal registers=0.
REQ-022 Reset SHALL take priority over start and over any in-progress RUN/DONE. An aborted operation SHALL produce no done pulse.
REQ-023 The first start SHALL be accepted on the first edge with rst=0.

Configuration
REQ-024 Macro SHIFT_ADD_MULT_SIGNED_EN SHALL select the operand interpretation.
REQ-025 Without the macro, a and b SHALL be unsigned and p=a*b unsigned.
REQ-026 With the macro, a and b SHALL be two's complement. At capture, the block SHALL store their magnitudes and the sign XOR, run the same unsigned datapath, and two's-complement negate the result when loading p if the sign XOR is 1. Latency SHALL be unchanged.
REQ-027 With the macro, the most-negative operand (-2^(WIDTH-1)) SHALL be handled correctly: its magnitude fits in WIDTH unsigned bits.

Verification (WIDTH=4)
REQ-028 Reset then a=15,b=15, start one cycle -> done exactly 4 edges after the accept edge, p=0xE1, ready returns 1 the following cycle.
REQ-029 a=0,b=9 then a=9,b=0 back-to-back (start held high) -> each gives p=0x00, done once each, accepts spaced 6 cycles apart.
REQ-030 a=6,b=7 accepted; start pulsed with a=1,b=1 during RUN and during DONE -> ignored, single done, p=0x2A.
REQ-031 a=13,b=11 accepted; rst=1 on the 2nd RUN edge -> p=0, done never asserts, ready=1 next cycle; a new start with a=3,b=5 then gives p=0x0F.
REQ-032 With SHIFT_ADD_MULT_SIGNED_EN: (-8)*(-8) -> p=0x40; (-8)*7 -> p=0xC8; 3*(-1) -> p=0xFD; same latency as unsigned.
REQ-033 Without the macro, the same bit patterns 8*8 -> p=0x40, 8*7 -> p=0x38, 3*15 -> p=0x2D.

Source files
------------

// File: rtl/shift_add_mult.sv
// Sequential shift-add multiplier.
// It multiplies two WIDTH-bit operands into a 2*WIDTH-bit product using
// one shift-add step per clock. One operation runs from the accept edge to
// a one-cycle done pulse, and takes WIDTH+2 cycles from accept to accept.
// Optional macro SHIFT_ADD_MULT_SIGNED_EN: when it is defined, the operands
// are two's complement. The block multiplies their magnitudes and negates
// the result when the operand signs differ.
module shift_add_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH:0]   r_prod;
    logic [CW-1:0]      r_count;

    logic [WIDTH-1:0]   w_capA;
    logic [WIDTH-1:0]   w_capB;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH:0]   w_stepProd;
    logic [2*WIDTH-1:0] w_result;
    logic [2*WIDTH-1:0] w_pLoad;
    logic               w_lastStep;

`ifdef SHIFT_ADD_MULT_SIGNED_EN
    logic               r_negate;
    logic               w_capNeg;

    // Convert signed operands to magnitudes. The most-negative value maps to 2^(WIDTH-1), which still fits.
    always_comb begin
        w_capA   = a[WIDTH-1] ? (~a + 1'b1) : a;
        w_capB   = b[WIDTH-1] ? (~b + 1'b1) : b;
        w_capNeg = a[WIDTH-1] ^ b[WIDTH-1];
    end
`else
    // Unsigned operands go straight into the datapath.
    always_comb begin
        w_capA = a;
        w_capB = b;
    end
`endif

    // Perform one shift-add step. The sum keeps a carry bit, then the whole partial product shifts right.
    always_comb begin
        w_sum      = r_prod[2*WIDTH:WIDTH] + (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
        w_stepProd = {w_sum, r_prod[WIDTH-1:0]} >> 1;
        w_result   = w_stepProd[2*WIDTH-1:0];
        w_lastStep = (r_state == RUN) && (r_count == LAST);
`ifdef SHIFT_ADD_MULT_SIGNED_EN
        w_pLoad    = r_negate ? (~w_result + 1'b1) : w_result;
`else
        w_pLoad    = w_result;
`endif
    end

    // State register. Reset returns to IDLE and discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and handshake outputs. ready is high only in IDLE, and done is high only in DONE.
    always_comb begin
        w_nextState = r_state;
        ready       = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (w_lastStep) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: capture operands on accept, step once per RUN cycle, and update p only on the final step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_count  <= '0;
            p        <= '0;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
            r_negate <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand  <= w_capA;
                        r_mplier <= w_capB;
                        r_prod   <= '0;
                        r_count  <= '0;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
                        r_negate <= w_capNeg;
`endif
                    end
                end
                RUN: begin
                    r_prod   <= w_stepProd;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CW'(1);
                    if (w_lastStep) begin
                        p <= w_pLoad;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult at WIDTH=4.
// Expected products come from plain integer arithmetic. When the bench is
// built with SHIFT_ADD_MULT_SIGNED_EN, the operands are read as two's
// complement.
module tb_shift_add_mult;

    localparam int W = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           ready;
    logic           done;
    logic [2*W-1:0] p;

    int vectors;
    int miscompares;

    shift_add_mult #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .done  (done),
        .p     (p)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product computed directly from the operand values.
    function automatic logic [2*W-1:0] modelProduct(input logic [W-1:0] x, input logic [W-1:0] y);
        longint vx;
        longint vy;
`ifdef SHIFT_ADD_MULT_SIGNED_EN
        vx = longint'($signed(x));
        vy = longint'($signed(y));
`else
        vx = longint'(x);
        vy = longint'(y);
`endif
        return (2*W)'(vx * vy);
    endfunction

    // Start one multiply from IDLE and watch it for a fixed number of cycles.
    // Operands are scrambled after the accept edge. lat stays -1 if no done pulse appears.
    task automatic applyStimulus(input logic [W-1:0] opA, input logic [W-1:0] opB,
                                 output int lat, output logic [2*W-1:0] prodSeen,
                                 output int doneSeen, output logic readyBack);
        lat       = -1;
        prodSeen  = '0;
        doneSeen  = 0;
        readyBack = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        a     = opA;
        b     = opB;
        for (int n = 1; n <= W + 3; n++) begin
            @(negedge clk);
            if (done) begin
                doneSeen++;
                if (lat < 0) begin
                    lat      = n - 1;
                    prodSeen = p;
                end
            end
            if (n == W + 2) readyBack = ready;
            if (n == 1) begin
                start = 1'b0;
                a     = W'($urandom());
                b     = W'($urandom());
            end
        end
    endtask

    task automatic test_reset;
        int lat, dn;
        logic [2*W-1:0] pr;
        logic rb;
        rst   = 1'b1;
        start = 1'b1;
        a     = 4'd5;
        b     = 4'd5;
        repeat (3) @(negedge clk);
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b expected 1", ready);
        end
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_done: got %b expected 0", done);
        end
        vectors++;
        if (p !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_p: got %h expected 00", p);
        end
        applyStimulus(4'd2, 4'd3, lat, pr, dn, rb);
        vectors++;
        if (lat !== W) begin
            miscompares++;
            $display("[TB] FAIL first_start_latency: got %0d expected %0d", lat, W);
        end
        vectors++;
        if (pr !== modelProduct(4'd2, 4'd3)) begin
            miscompares++;
            $display("[TB] FAIL first_start_p: got %h expected %h", pr, modelProduct(4'd2, 4'd3));
        end
    endtask

    task automatic test_max;
        int lat, dn;
        logic [2*W-1:0] pr;
        logic rb;
        applyStimulus(4'd15, 4'd15, lat, pr, dn, rb);
        vectors++;
        if (lat !== W) begin
            miscompares++;
            $display("[TB] FAIL max_latency: got %0d expected %0d", lat, W);
        end
        vectors++;
        if (pr !== modelProduct(4'd15, 4'd15)) begin
            miscompares++;
            $display("[TB] FAIL max_p: got %h expected %h", pr, modelProduct(4'd15, 4'd15));
        end
        vectors++;
        if (dn !== 1) begin
            miscompares++;
            $display("[TB] FAIL max_done_count: got %0d expected 1", dn);
        end
        vectors++;
        if (rb !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL max_ready_back: got %b expected 1", rb);
        end
    endtask

    task automatic test_back_to_back;
        int accepts[$];
        logic [2*W-1:0] pvals[$];
        @(negedge clk);
        start = 1'b1;
        a     = 4'd0;
        b     = 4'd9;
        for (int n = 0; n <= 13; n++) begin
            if (n > 0) @(negedge clk);
            if (ready && start) accepts.push_back(n);
            if (done) pvals.push_back(p);
            if (n == 1) begin
                a = 4'd9;
                b = 4'd0;
            end
            if (n == 11) start = 1'b0;
        end
        vectors++;
        if (accepts.size() !== 2) begin
            miscompares++;
            $display("[TB] FAIL b2b_accept_count: got %0d expected 2", accepts.size());
        end else begin
            vectors++;
            if (accepts[1] - accepts[0] !== W + 2) begin
                miscompares++;
                $display("[TB] FAIL b2b_spacing: got %0d expected %0d", accepts[1] - accepts[0], W + 2);
            end
        end
        vectors++;
        if (pvals.size() !== 2) begin
            miscompares++;
            $display("[TB] FAIL b2b_done_count: got %0d expected 2", pvals.size());
        end else begin
            vectors++;
            if (pvals[0] !== modelProduct(4'd0, 4'd9) || pvals[1] !== modelProduct(4'd9, 4'd0)) begin
                miscompares++;
                $display("[TB] FAIL b2b_p: got %h,%h expected 00,00", pvals[0], pvals[1]);
            end
        end
    endtask

    task automatic test_ignore_start;
        int dones;
        logic [2*W-1:0] prevP;
        logic [2*W-1:0] firstP;
        dones  = 0;
        firstP = '0;
        @(negedge clk);
        prevP = p;
        start = 1'b1;
        a     = 4'd6;
        b     = 4'd7;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (done) begin
                if (dones == 0) firstP = p;
                dones++;
            end
            if (n == 3) begin
                vectors++;
                if (p !== prevP) begin
                    miscompares++;
                    $display("[TB] FAIL ignore_p_hold: got %h expected %h", p, prevP);
                end
            end
            if (n == 1) start = 1'b0;
            if (n == 2) begin
                start = 1'b1;
                a     = 4'd1;
                b     = 4'd1;
            end
            if (n == 3) start = 1'b0;
            if (n == 5) begin
                start = 1'b1;
                a     = 4'd1;
                b     = 4'd1;
            end
            if (n == 6) start = 1'b0;
        end
        vectors++;
        if (dones !== 1) begin
            miscompares++;
            $display("[TB] FAIL ignore_done_count: got %0d expected 1", dones);
        end
        vectors++;
        if (firstP !== modelProduct(4'd6, 4'd7)) begin
            miscompares++;
            $display("[TB] FAIL ignore_p: got %h expected %h", firstP, modelProduct(4'd6, 4'd7));
        end
        vectors++;
        if (p !== modelProduct(4'd6, 4'd7)) begin
            miscompares++;
            $display("[TB] FAIL ignore_p_final: got %h expected %h", p, modelProduct(4'd6, 4'd7));
        end
    endtask

    task automatic test_reset_abort;
        int dones;
        int lat, dn;
        logic [2*W-1:0] pr;
        logic rb;
        dones = 0;
        @(negedge clk);
        start = 1'b1;
        a     = 4'd13;
        b     = 4'd11;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (done) dones++;
            if (n == 3) begin
                vectors++;
                if (ready !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL abort_ready: got %b expected 1", ready);
                end
                vectors++;
                if (p !== '0) begin
                    miscompares++;
                    $display("[TB] FAIL abort_p: got %h expected 00", p);
                end
            end
            if (n == 1) start = 1'b0;
            if (n == 2) rst = 1'b1;
            if (n == 3) rst = 1'b0;
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("[TB] FAIL abort_done_count: got %0d expected 0", dones);
        end
        applyStimulus(4'd3, 4'd5, lat, pr, dn, rb);
        vectors++;
        if (pr !== modelProduct(4'd3, 4'd5) || lat !== W) begin
            miscompares++;
            $display("[TB] FAIL abort_restart: got p=%h lat=%0d expected p=%h lat=%0d",
                     pr, lat, modelProduct(4'd3, 4'd5), W);
        end
    endtask

    task automatic test_boundary;
        logic [W-1:0]   opsA [3];
        logic [W-1:0]   opsB [3];
        logic [2*W-1:0] want [3];
        int lat, dn;
        logic [2*W-1:0] pr;
        logic rb;
        opsA = '{4'd8, 4'd8, 4'd3};
        opsB = '{4'd8, 4'd7, 4'd15};
`ifdef SHIFT_ADD_MULT_SIGNED_EN
        want = '{8'h40, 8'hC8, 8'hFD};
`else
        want = '{8'h40, 8'h38, 8'h2D};
`endif
        for (int i = 0; i < 3; i++) begin
            applyStimulus(opsA[i], opsB[i], lat, pr, dn, rb);
            vectors++;
            if (pr !== want[i] || lat !== W) begin
                miscompares++;
                $display("[TB] FAIL boundary_%0d: got p=%h lat=%0d expected p=%h lat=%0d",
                         i, pr, lat, want[i], W);
            end
        end
    endtask

    task automatic test_random;
        int lat, dn;
        logic [2*W-1:0] pr;
        logic rb;
        logic [W-1:0] ra;
        logic [W-1:0] rbv;
        for (int i = 0; i < 24; i++) begin
            ra  = W'($urandom());
            rbv = W'($urandom());
            applyStimulus(ra, rbv, lat, pr, dn, rb);
            vectors++;
            if (pr !== modelProduct(ra, rbv) || lat !== W || dn !== 1 || rb !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL random_%0d: a=%h b=%h got p=%h lat=%0d dones=%0d ready=%b expected p=%h lat=%0d dones=1 ready=1",
                         i, ra, rbv, pr, lat, dn, rb, modelProduct(ra, rbv), W);
            end
        end
    endtask

    // Run every scenario in order, then print the summary.
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        test_reset();
        test_max();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
        test_boundary();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
